// File: rtl/vend_coin_sequencer_if.sv
// vend_coin_sequencer_if: coin slots, core pulse/open and dispenser handshake of the coin sequencer.
interface vend_coin_sequencer_if;
  logic s0_vld, s0_dime, s0_rdy;
  logic s1_vld, s1_dime, s1_rdy;
  logic core_n, core_d, core_open;
  logic disp_req, disp_ack;
  modport master(
    output s0_vld, s0_dime, s1_vld, s1_dime, core_open, disp_ack,
    input  s0_rdy, s1_rdy, core_n, core_d, disp_req
  );
  modport slave(
    input  s0_vld, s0_dime, s1_vld, s1_dime, core_open, disp_ack,
    output s0_rdy, s1_rdy, core_n, core_d, disp_req
  );
endinterface

// File: rtl/vend_coin_sequencer.sv
// vend_coin_sequencer: round-robin coin intake, coin FIFO, one-coin-at-a-time core feed and dispenser handshake.
// Optional VEND_SEQ_STATS_EN adds saturating nickel_cnt/dime_cnt of coins issued to the core.
module vend_coin_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8,
  parameter int ACK_TMO    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  vend_coin_sequencer_if.slave bus,
  output logic [CNT_W-1:0]     vend_cnt,
  output logic                 fault,
  output logic                 fifo_full
`ifdef VEND_SEQ_STATS_EN
  ,
  output logic [CNT_W-1:0]     nickel_cnt,
  output logic [CNT_W-1:0]     dime_cnt
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(ACK_TMO + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, SAMPLE, DISP, HALT} state_t;
  state_t state, state_nx;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic mem [FIFO_DEPTH];
  logic rr, typ, g0, g1, push, push_dime, pop, vend, tmo;
  logic [TW-1:0] timer;
  assign fifo_full = count == (AW+1)'(FIFO_DEPTH);
  // Ready is gated by the registered full flag, so a full FIFO never takes a push even when popping.
  always_comb begin
    g0 = bus.s0_vld & (!bus.s1_vld | !rr);
    g1 = bus.s1_vld & (!bus.s0_vld | rr);
    bus.s0_rdy = g0 & !fifo_full & !rst;
    bus.s1_rdy = g1 & !fifo_full & !rst;
    push = bus.s0_rdy | bus.s1_rdy;
    push_dime = bus.s0_rdy ? bus.s0_dime : bus.s1_dime;
  end
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    vend = 1'b0;
    tmo = 1'b0;
    case (state)
      IDLE: begin
        pop = count != '0 && !fault;
        state_nx = pop ? ISSUE : IDLE;
      end
      ISSUE:  state_nx = SAMPLE;
      SAMPLE: state_nx = bus.core_open ? DISP : IDLE;
      DISP: begin
        vend = bus.disp_ack;
        tmo = !bus.disp_ack && timer == TW'(ACK_TMO - 1);
        state_nx = vend ? IDLE : tmo ? HALT : DISP;
      end
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
    bus.core_n = state == ISSUE && !typ;
    bus.core_d = state == ISSUE && typ;
    bus.disp_req = state == DISP;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      rr <= 1'b0;
      typ <= 1'b0;
      timer <= '0;
      vend_cnt <= '0;
      fault <= 1'b0;
    end else begin
      state <= state_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        typ <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (push && bus.s0_vld && bus.s1_vld) rr <= !rr;
      timer <= state == DISP ? timer + 1'b1 : '0;
      if (vend && vend_cnt != '1) vend_cnt <= vend_cnt + 1'b1;
      if (tmo) fault <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dime;
  end
`ifdef VEND_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      nickel_cnt <= '0;
      dime_cnt <= '0;
    end else if (state == ISSUE) begin
      if (!typ && nickel_cnt != '1) nickel_cnt <= nickel_cnt + 1'b1;
      if (typ && dime_cnt != '1) dime_cnt <= dime_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_vend_coin_sequencer.sv
// tb_vend_coin_sequencer: directed and random scenarios against a 15-cent Moore core model and a coin scoreboard.
module tb_vend_coin_sequencer;
  localparam int CNT_W = 2;
  localparam int SAT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  vend_coin_sequencer_if u();
  logic [CNT_W-1:0] vend_cnt;
  logic fault, fifo_full;
`ifdef VEND_SEQ_STATS_EN
  logic [CNT_W-1:0] nickel_cnt, dime_cnt;
`endif
  vend_coin_sequencer #(.FIFO_DEPTH(4), .CNT_W(CNT_W), .ACK_TMO(15)) dut (
    .clk(clk), .rst(rst), .bus(u), .vend_cnt(vend_cnt), .fault(fault), .fifo_full(fifo_full)
`ifdef VEND_SEQ_STATS_EN
    , .nickel_cnt(nickel_cnt), .dime_cnt(dime_cnt)
`endif
  );
  // Core model: holds the inserted amount, opens for one cycle at 15 cents or more, then starts over.
  int amt;
  assign u.core_open = amt >= 15;
  always @(posedge clk) amt <= rst ? 0 : amt >= 15 ? 0 : amt + (u.core_n ? 5 : 0) + (u.core_d ? 10 : 0);
  bit ack_en, ack_force, ack_rand;
  int ack_dly, cur_dly, ack_cnt;
  always @(negedge clk) begin
    if (u.disp_req && ack_en) begin
      u.disp_ack = ack_force || ack_cnt == cur_dly;
      ack_cnt++;
    end else begin
      u.disp_ack = ack_force;
      ack_cnt = 0;
      cur_dly = ack_rand ? int'($urandom_range(0, 14)) : ack_dly;
    end
  end
  bit acc_q[$], acc_slot[$], pul_q[$];
  int acc_cyc[$], pul_cyc[$], rise_q[$];
  int cyc, disp_hi, both_cnt;
  bit req_prev;
  always @(posedge clk) begin
    if (rst) begin
      acc_q.delete(); acc_slot.delete(); acc_cyc.delete();
      pul_q.delete(); pul_cyc.delete(); rise_q.delete();
      disp_hi = 0;
      both_cnt = 0;
    end else begin
      if (u.s0_vld && u.s0_rdy) begin acc_q.push_back(u.s0_dime); acc_slot.push_back(1'b0); acc_cyc.push_back(cyc); end
      if (u.s1_vld && u.s1_rdy) begin acc_q.push_back(u.s1_dime); acc_slot.push_back(1'b1); acc_cyc.push_back(cyc); end
      if (u.core_n && u.core_d) both_cnt++;
      if (u.core_n || u.core_d) begin pul_q.push_back(u.core_d); pul_cyc.push_back(cyc); end
      if (u.disp_req) begin
        disp_hi++;
        if (!req_prev) rise_q.push_back(cyc);
      end
    end
    req_prev = !rst && u.disp_req;
    cyc++;
  end
  int n_cmp, n_bad;
  bit ok;
  function automatic int model_vends();
    int a = 0, v = 0;
    foreach (acc_q[i]) begin
      a += acc_q[i] ? 10 : 5;
      if (a >= 15) begin v++; a = 0; end
    end
    return v;
  endfunction
  task automatic do_reset();
    rst = 1'b1;
    u.s0_vld = 1'b0; u.s1_vld = 1'b0; u.s0_dime = 1'b0; u.s1_dime = 1'b0;
    ack_en = 1'b0; ack_force = 1'b0; ack_rand = 1'b0; ack_dly = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic feed(input bit slot, input logic [15:0] dimes, input int n, input int budget, output bit done);
    int base, k;
    base = acc_q.size();
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      k = acc_q.size() - base;
      if (k >= n) begin done = 1'b1; break; end
      if (slot) begin u.s1_vld = 1'b1; u.s1_dime = dimes[k]; end
      else begin u.s0_vld = 1'b1; u.s0_dime = dimes[k]; end
    end
    if (slot) u.s1_vld = 1'b0; else u.s0_vld = 1'b0;
  endtask
  task automatic wait_quiet(input int n, input int budget, output bit done);
    int quiet = 0;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      quiet = (pul_q.size() >= n && !u.disp_req) ? quiet + 1 : 0;
      if (quiet >= 3) begin done = 1'b1; break; end
    end
  endtask
  task automatic wait_req(output bit done);
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (u.disp_req) begin done = 1'b1; break; end
    end
  endtask
  task automatic test_reset();
    u.s0_vld = 1'b1; u.s1_vld = 1'b1; u.s0_dime = 1'b0; u.s1_dime = 1'b1;
    ack_en = 1'b0; ack_force = 1'b0; ack_rand = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp += 8;
    if (u.s0_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_s0_rdy: got %b expected 0", u.s0_rdy); end
    if (u.s1_rdy !== 1'b0) begin n_bad++; $display("FAIL reset_s1_rdy: got %b expected 0", u.s1_rdy); end
    if (u.core_n !== 1'b0) begin n_bad++; $display("FAIL reset_core_n: got %b expected 0", u.core_n); end
    if (u.core_d !== 1'b0) begin n_bad++; $display("FAIL reset_core_d: got %b expected 0", u.core_d); end
    if (u.disp_req !== 1'b0) begin n_bad++; $display("FAIL reset_disp_req: got %b expected 0", u.disp_req); end
    if (vend_cnt !== 2'd0) begin n_bad++; $display("FAIL reset_vend_cnt: got %0d expected 0", vend_cnt); end
    if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault: got %b expected 0", fault); end
    if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_full: got %b expected 0", fifo_full); end
    u.s0_vld = 1'b0; u.s1_vld = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_three_nickels();
    do_reset();
    ack_en = 1'b1; ack_dly = 2;
    feed(1'b0, 16'h0, 3, 20, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL nick_feed: got %b expected 1", ok); end
    wait_quiet(3, 80, ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL nick_drain: got %b expected 1", ok); end
    n_cmp += 9;
    if (acc_cyc[2] - acc_cyc[0] !== 2) begin n_bad++; $display("FAIL nick_b2b: got %0d expected 2", acc_cyc[2] - acc_cyc[0]); end
    if (pul_q.size() !== 3) begin n_bad++; $display("FAIL nick_pulses: got %0d expected 3", pul_q.size()); end
    if (pul_q.sum() with (int'(item)) !== 0) begin n_bad++; $display("FAIL nick_types: got %0d dimes expected 0", pul_q.sum() with (int'(item))); end
    if (pul_cyc[0] - acc_cyc[0] !== 2) begin n_bad++; $display("FAIL nick_latency: got %0d expected 2", pul_cyc[0] - acc_cyc[0]); end
    if (pul_cyc[1] - pul_cyc[0] !== 3) begin n_bad++; $display("FAIL nick_gap1: got %0d expected 3", pul_cyc[1] - pul_cyc[0]); end
    if (pul_cyc[2] - pul_cyc[1] !== 3) begin n_bad++; $display("FAIL nick_gap2: got %0d expected 3", pul_cyc[2] - pul_cyc[1]); end
    if (rise_q.size() !== 1) begin n_bad++; $display("FAIL nick_req_count: got %0d expected 1", rise_q.size()); end
    if (rise_q[0] - pul_cyc[2] !== 2) begin n_bad++; $display("FAIL nick_req_latency: got %0d expected 2", rise_q[0] - pul_cyc[2]); end
    if (vend_cnt !== 2'd1) begin n_bad++; $display("FAIL nick_vend_cnt: got %0d expected 1", vend_cnt); end
  endtask
  task automatic test_round_robin();
    int base, k0, k1;
    logic [4:0] got_slot, got_pul;
    do_reset();
    ack_en = 1'b1; ack_dly = 0;
    feed(1'b1, 16'h0, 1, 10, ok);
    base = acc_slot.size();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      k0 = 0; k1 = 0;
      for (int j = base; j < acc_slot.size(); j++) if (acc_slot[j]) k1++; else k0++;
      if (k0 >= 2 && k1 >= 2) break;
      u.s0_vld = k0 < 2; u.s0_dime = 1'b1;
      u.s1_vld = k1 < 2; u.s1_dime = 1'b0;
    end
    u.s0_vld = 1'b0; u.s1_vld = 1'b0;
    wait_quiet(5, 100, ok);
    for (int i = 0; i < 5; i++) begin got_slot[i] = acc_slot[i]; got_pul[i] = pul_q[i]; end
    n_cmp += 6;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL rr_drain: got %b expected 1", ok); end
    if (acc_q.size() !== 5) begin n_bad++; $display("FAIL rr_accepts: got %0d expected 5", acc_q.size()); end
    if (got_slot !== 5'b10101) begin n_bad++; $display("FAIL rr_order: got %b expected 10101", got_slot); end
    if (pul_q.size() !== 5 || got_pul !== 5'b01010) begin n_bad++; $display("FAIL rr_pulses: got %b (n=%0d) expected 01010", got_pul, pul_q.size()); end
    if (vend_cnt !== 2'd2) begin n_bad++; $display("FAIL rr_vend_cnt: got %0d expected 2", vend_cnt); end
    if (both_cnt !== 0) begin n_bad++; $display("FAIL rr_both: got %0d expected 0", both_cnt); end
  endtask
  task automatic test_timeout();
    do_reset();
    ack_en = 1'b0;
    feed(1'b0, 16'h0001, 2, 20, ok);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fault) break;
    end
    #1;
    n_cmp += 4;
    if (fault !== 1'b1) begin n_bad++; $display("FAIL tmo_fault: got %b expected 1", fault); end
    if (u.disp_req !== 1'b0) begin n_bad++; $display("FAIL tmo_disp_req: got %b expected 0", u.disp_req); end
    if (disp_hi !== 15) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d expected 15", disp_hi); end
    if (vend_cnt !== 2'd0) begin n_bad++; $display("FAIL tmo_vend_cnt: got %0d expected 0", vend_cnt); end
    ack_force = 1'b1;
    feed(1'b0, 16'h0, 5, 20, ok);
    u.s0_vld = 1'b1;
    #1;
    n_cmp += 6;
    if (ok !== 1'b0) begin n_bad++; $display("FAIL halt_feed_done: got %b expected 0", ok); end
    if (acc_q.size() !== 6) begin n_bad++; $display("FAIL halt_accepts: got %0d expected 6", acc_q.size()); end
    if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL halt_full: got %b expected 1", fifo_full); end
    if (u.s0_rdy !== 1'b0) begin n_bad++; $display("FAIL halt_rdy: got %b expected 0", u.s0_rdy); end
    if (pul_q.size() !== 2) begin n_bad++; $display("FAIL halt_pulses: got %0d expected 2", pul_q.size()); end
    if (vend_cnt !== 2'd0) begin n_bad++; $display("FAIL halt_ack_ignored: got %0d expected 0", vend_cnt); end
    u.s0_vld = 1'b0;
    ack_force = 1'b0;
  endtask
  task automatic test_fill_in_disp();
    do_reset();
    ack_en = 1'b0; ack_dly = 0;
    feed(1'b0, 16'h0, 3, 20, ok);
    wait_req(ok);
    n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL fill_req: got %b expected 1", ok); end
    feed(1'b0, 16'h0, 4, 10, ok);
    @(negedge clk);
    u.s0_vld = 1'b1; u.s0_dime = 1'b0;
    #1;
    n_cmp += 3;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL fill_feed: got %b expected 1", ok); end
    if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b expected 1", fifo_full); end
    if (u.s0_rdy !== 1'b0) begin n_bad++; $display("FAIL fill_rdy: got %b expected 0", u.s0_rdy); end
    ack_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    n_cmp += 2;
    if (fifo_full !== 1'b1) begin n_bad++; $display("FAIL fill_full_at_pop: got %b expected 1", fifo_full); end
    if (vend_cnt !== 2'd1) begin n_bad++; $display("FAIL fill_vend1: got %0d expected 1", vend_cnt); end
    @(negedge clk);
    #1;
    n_cmp += 2;
    if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL fill_full_after_pop: got %b expected 0", fifo_full); end
    if (u.s0_rdy !== 1'b1) begin n_bad++; $display("FAIL fill_rdy_after_pop: got %b expected 1", u.s0_rdy); end
    @(negedge clk);
    u.s0_vld = 1'b0;
    wait_quiet(8, 200, ok);
    n_cmp += 3;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL fill_drain: got %b expected 1", ok); end
    if (pul_q.size() !== 8) begin n_bad++; $display("FAIL fill_pulses: got %0d expected 8", pul_q.size()); end
    if (vend_cnt !== 2'd2) begin n_bad++; $display("FAIL fill_vend2: got %0d expected 2", vend_cnt); end
  endtask
  task automatic test_reset_in_disp();
    do_reset();
    ack_en = 1'b1; ack_dly = 1;
    feed(1'b0, 16'h0, 3, 20, ok);
    wait_quiet(3, 80, ok);
    n_cmp++; if (vend_cnt !== 2'd1) begin n_bad++; $display("FAIL rst_pre_vend: got %0d expected 1", vend_cnt); end
    ack_en = 1'b0;
    feed(1'b0, 16'h0, 3, 20, ok);
    wait_req(ok);
    feed(1'b0, 16'h0, 2, 10, ok);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_cmp += 3;
    if (u.disp_req !== 1'b0) begin n_bad++; $display("FAIL rst_disp_req: got %b expected 0", u.disp_req); end
    if (fifo_full !== 1'b0) begin n_bad++; $display("FAIL rst_full: got %b expected 0", fifo_full); end
    if (vend_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_vend_cnt: got %0d expected 0", vend_cnt); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_cmp += 2;
    if (pul_q.size() !== 0) begin n_bad++; $display("FAIL rst_fifo_empty: got %0d pulses expected 0", pul_q.size()); end
    if (u.disp_req !== 1'b0) begin n_bad++; $display("FAIL rst_idle: got %b expected 0", u.disp_req); end
  endtask
  task automatic test_saturation();
    do_reset();
    ack_en = 1'b1; ack_dly = 14;
    feed(1'b0, 16'h0, 12, 400, ok);
    wait_quiet(12, 400, ok);
    n_cmp += 4;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL sat_drain: got %b expected 1", ok); end
    if (rise_q.size() !== 4) begin n_bad++; $display("FAIL sat_vends: got %0d expected 4", rise_q.size()); end
    if (vend_cnt !== 2'(SAT)) begin n_bad++; $display("FAIL sat_vend_cnt: got %0d expected %0d", vend_cnt, SAT); end
    if (fault !== 1'b0) begin n_bad++; $display("FAIL sat_late_ack: got fault %b expected 0", fault); end
`ifdef VEND_SEQ_STATS_EN
    n_cmp += 2;
    if (nickel_cnt !== 2'(SAT)) begin n_bad++; $display("FAIL sat_nickel_cnt: got %0d expected %0d", nickel_cnt, SAT); end
    if (dime_cnt !== 2'd0) begin n_bad++; $display("FAIL sat_dime_cnt: got %0d expected 0", dime_cnt); end
`endif
  endtask
  task automatic test_random();
    logic [5:0] l0, l1, g0, g1;
    logic [11:0] ga, gp;
    int k0, k1, mg, ev, nd;
    do_reset();
    ack_en = 1'b1; ack_rand = 1'b1;
    l0 = 6'($urandom); l1 = 6'($urandom);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      k0 = 0; k1 = 0;
      foreach (acc_slot[j]) if (acc_slot[j]) k1++; else k0++;
      if (k0 >= 6 && k1 >= 6) break;
      u.s0_vld = k0 < 6 && $urandom_range(0, 3) != 0; u.s0_dime = l0[k0 % 6];
      u.s1_vld = k1 < 6 && $urandom_range(0, 3) != 0; u.s1_dime = l1[k1 % 6];
    end
    u.s0_vld = 1'b0; u.s1_vld = 1'b0;
    wait_quiet(12, 600, ok);
    k0 = 0; k1 = 0; g0 = '0; g1 = '0; ga = '0; gp = '0; mg = 1000;
    foreach (acc_q[j]) begin
      if (acc_slot[j]) begin if (k1 < 6) g1[k1] = acc_q[j]; k1++; end
      else begin if (k0 < 6) g0[k0] = acc_q[j]; k0++; end
      if (j < 12) ga[j] = acc_q[j];
    end
    foreach (pul_q[j]) if (j < 12) gp[j] = pul_q[j];
    for (int j = 1; j < pul_cyc.size(); j++) if (pul_cyc[j] - pul_cyc[j-1] < mg) mg = pul_cyc[j] - pul_cyc[j-1];
    ev = model_vends();
    ev = ev > SAT ? SAT : ev;
    nd = acc_q.sum() with (int'(item));
    n_cmp += 8;
    if (ok !== 1'b1) begin n_bad++; $display("FAIL rnd_drain: got %b expected 1", ok); end
    if (g0 !== l0 || k0 !== 6) begin n_bad++; $display("FAIL rnd_slot0: got %b (n=%0d) expected %b", g0, k0, l0); end
    if (g1 !== l1 || k1 !== 6) begin n_bad++; $display("FAIL rnd_slot1: got %b (n=%0d) expected %b", g1, k1, l1); end
    if (pul_q.size() !== 12 || gp !== ga) begin n_bad++; $display("FAIL rnd_pulse_order: got %b (n=%0d) expected %b", gp, pul_q.size(), ga); end
    if (both_cnt !== 0) begin n_bad++; $display("FAIL rnd_both: got %0d expected 0", both_cnt); end
    if (mg < 3) begin n_bad++; $display("FAIL rnd_gap: got %0d expected >=3", mg); end
    if (vend_cnt !== 2'(ev)) begin n_bad++; $display("FAIL rnd_vend_cnt: got %0d expected %0d", vend_cnt, ev); end
    if (fault !== 1'b0) begin n_bad++; $display("FAIL rnd_fault: got %b expected 0", fault); end
`ifdef VEND_SEQ_STATS_EN
    n_cmp += 2;
    if (dime_cnt !== 2'(nd > SAT ? SAT : nd)) begin n_bad++; $display("FAIL rnd_dime_cnt: got %0d expected %0d", dime_cnt, nd > SAT ? SAT : nd); end
    if (nickel_cnt !== 2'(12 - nd > SAT ? SAT : 12 - nd)) begin n_bad++; $display("FAIL rnd_nickel_cnt: got %0d expected %0d", nickel_cnt, 12 - nd > SAT ? SAT : 12 - nd); end
`endif
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_three_nickels();
    test_round_robin();
    test_timeout();
    test_fill_in_disp();
    test_reset_in_disp();
    test_saturation();
    test_random();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
